// File: rtl/axi4_lite_master.sv
// -----------------------------------------------------------------------------
// axi4_lite_master
//
// Single-outstanding AXI4-Lite master. Accepts one read or write command on a
// valid/ready command port, runs the matching AXI4-Lite transaction and
// returns the read data / response code on a valid/ready response port.
//
// Ports
//   aclk, aresetn                      clock, async active-low reset
//   cmd_valid/cmd_ready                command handshake (cmd_ready decoded)
//   cmd_write/addr/wdata/wstrb/prot    command payload
//   rsp_valid/rsp_ready                response handshake
//   rsp_write/rsp_rdata/rsp_resp       response payload
//   aw*, w*, b*, ar*, r*               AXI4-Lite master channels
//
// Optional feature (macro AXI4_MASTER_TIMEOUT_EN):
//   TIMEOUT_W-bit watchdog that abandons a stalled transaction and reports
//   rsp_resp = 2'b11. Without the macro the master waits indefinitely.
// -----------------------------------------------------------------------------
module axi4_lite_master #(
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic        aclk,
   input  logic        aresetn,
   // command port
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_wstrb,
   input  logic [2:0]  cmd_prot,
   // response port
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_write,
   output logic [31:0] rsp_rdata,
   output logic [1:0]  rsp_resp,
   // write address
   output logic        awvalid,
   input  logic        awready,
   output logic [15:0] awaddr,
   output logic [2:0]  awprot,
   // write data
   output logic        wvalid,
   input  logic        wready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   // write response
   input  logic        bvalid,
   output logic        bready,
   input  logic [1:0]  bresp,
   // read address
   output logic        arvalid,
   input  logic        arready,
   output logic [15:0] araddr,
   output logic [2:0]  arprot,
   // read data
   input  logic        rvalid,
   output logic        rready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StWrite = 3'd1;
   localparam logic [2:0] StWresp = 3'd2;
   localparam logic [2:0] StRaddr = 3'd3;
   localparam logic [2:0] StRdata = 3'd4;
   localparam logic [2:0] StResp  = 3'd5;

   logic [2:0]  state_q, state_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        bready_q, bready_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_write_q, rsp_write_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]  rsp_resp_q, rsp_resp_d;
   logic [15:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic [2:0]  prot_q, prot_d;
   logic        tmo_fire;

`ifdef AXI4_MASTER_TIMEOUT_EN
   localparam logic [TIMEOUT_W-1:0] TmoMax = '1;

   logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic                 tmo_busy;

   assign tmo_busy = (state_q == StWrite) || (state_q == StWresp) ||
                     (state_q == StRaddr) || (state_q == StRdata);
   // Fires on the cycle whose increment would saturate the counter.
   assign tmo_fire = tmo_busy && ((tmo_cnt_q + 1'b1) == TmoMax);

   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      if (state_d != state_q) begin
         tmo_cnt_d = '0;
      end else if (tmo_busy) begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   logic unused_timeout_w;
   assign unused_timeout_w = (TIMEOUT_W != 0);
   assign tmo_fire         = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      rsp_valid_d = rsp_valid_q;
      rsp_write_d = rsp_write_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_resp_d  = rsp_resp_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      prot_d      = prot_q;

      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               wstrb_d = cmd_wstrb;
               prot_d  = cmd_prot;
               if (cmd_write) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  state_d   = StWrite;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = StRaddr;
               end
            end
         end
         StWrite: begin
            // AW and W retire independently; each valid drops after its own handshake.
            if (awvalid_q && awready) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (wvalid_q && wready) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if (aw_done_d && w_done_d) begin
               bready_d = 1'b1;
               state_d  = StWresp;
            end
         end
         StWresp: begin
            if (bvalid) begin
               bready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b1;
               rsp_rdata_d = '0;
               rsp_resp_d  = bresp;
               state_d     = StResp;
            end
         end
         StRaddr: begin
            if (arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = StRdata;
            end
         end
         StRdata: begin
            if (rvalid) begin
               rready_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_write_d = 1'b0;
               rsp_rdata_d = rdata;
               rsp_resp_d  = rresp;
               state_d     = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A handshake completing on the same cycle takes precedence over the watchdog.
      if (tmo_fire && (state_d == state_q)) begin
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         bready_d    = 1'b0;
         arvalid_d   = 1'b0;
         rready_d    = 1'b0;
         rsp_valid_d = 1'b1;
         rsp_write_d = (state_q == StWrite) || (state_q == StWresp);
         rsp_rdata_d = '0;
         rsp_resp_d  = 2'b11;
         state_d     = StResp;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= StIdle;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         prot_q      <= '0;
      end else begin
         state_q     <= state_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         bready_q    <= bready_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_resp_q  <= rsp_resp_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         prot_q      <= prot_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;
   assign awvalid   = awvalid_q;
   assign awaddr    = addr_q;
   assign awprot    = prot_q;
   assign wvalid    = wvalid_q;
   assign wdata     = wdata_q;
   assign wstrb     = wstrb_q;
   assign bready    = bready_q;
   assign arvalid   = arvalid_q;
   assign araddr    = addr_q;
   assign arprot    = prot_q;
   assign rready    = rready_q;

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

Single-outstanding AXI4-Lite master that sits directly upstream of the `axi4_dut` slave and drives its five channels. It accepts one read or write command at a time on a simple valid/ready command port, performs the corresponding AXI4-Lite transaction, and returns the read data and response code on a valid/ready response port. It is the bus driver used by the block-level bench and by any internal controller that needs register access to the slave.

## Interface
- TIMEOUT_W, 8, width of the watchdog counter; the timeout fires after 2^TIMEOUT_W−1 cycles (only with AXI4_MASTER_TIMEOUT_EN).
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  reset; asynchronous assertion, active-low, single clock domain.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  16  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write byte strobes.
- cmd_prot  in  3  protection bits, copied to awprot or arprot.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echoes cmd_write of the completed command.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  bresp or rresp as captured; 2'b11 on timeout.
- awvalid/awready/awaddr[15:0]/awprot[2:0]  out/in/out/out  write-address channel.
- wvalid/wready/wdata[31:0]/wstrb[3:0]  out/in/out/out  write-data channel.
- bvalid/bready/bresp[1:0]  in/out/in  write-response channel.
- arvalid/arready/araddr[15:0]/arprot[2:0]  out/in/out/out  read-address channel.
- rvalid/rready/rdata[31:0]/rresp[1:0]  in/out/in/in  read-data channel.

## Operation
- States: IDLE, WRITE (AW+W), WRESP, RADDR, RDATA, RESP.
- IDLE: cmd_ready=1. On cmd_valid: register the address, data, strobes and prot. Go to WRITE if cmd_write, else RADDR.
- WRITE:
  - awvalid and wvalid are asserted together.
  - Each channel has its own done flag. A valid drops the cycle after its own handshake.
  - When both flags are set, go to WRESP. AW and W may complete in the same cycle or in either order.
- WRESP: bready=1. On bvalid, capture bresp, set rsp_rdata=0, go to RESP.
- RADDR: arvalid=1. On arready, go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata and rresp, go to RESP.
- RESP:
  - rsp_valid=1, held stable until rsp_ready.
  - On rsp_ready, go to IDLE. cmd_ready rises in the next cycle, so back-to-back commands are spaced by at least one IDLE cycle.
- Handshake rules:
  - Once a valid is asserted, it stays high, with stable address and data, until its ready is sampled.
  - awaddr, araddr, wdata, wstrb and the prot outputs hold the last command's values at all times.
- Every bresp/rresp value is passed through unmodified. The master never retries.

## Timing
- All outputs are registered except cmd_ready, which is decoded from the state register.
- Reset values: state=IDLE; awvalid, wvalid, bready, arvalid, rready, rsp_valid = 0; all address, data, strobe, prot and rsp fields = 0. cmd_ready=1 once aresetn is high.
- Write, zero-wait slave:
  - Command accepted at cycle 0; awvalid/wvalid at cycle 1.
  - bready at cycle 2; bvalid sampled at cycle 2.
  - rsp_valid at cycle 3.
- Read, zero-wait slave: arvalid at cycle 1, rready at cycle 2, rsp_valid at cycle 3.
- rready and bready are asserted only in RDATA and WRESP respectively. A response arriving earlier waits.
- Reset mid-transaction: all outputs clear immediately (asynchronously) and the state returns to IDLE. The in-flight command is discarded with no rsp_valid.

## Configuration
- AXI4_MASTER_TIMEOUT_EN defined:
  - A TIMEOUT_W-bit counter clears on every state change and increments in WRITE, WRESP, RADDR and RDATA.
  - On saturation, all bus valids and readies drop, rsp_resp=2'b11, rsp_rdata=0, and the state goes to RESP.
  - This is a deliberate protocol break, for the bench and debug only.
- AXI4_MASTER_TIMEOUT_EN undefined: no counter. The master waits indefinitely, and the TIMEOUT_W parameter is unused.

## Test plan
- Write 0x0010 ← 0xDEADBEEF, strb 4'hF, zero-wait slave -> awvalid/wvalid at cycle 1; rsp_valid at cycle 3 with rsp_write=1, rsp_resp=2'b00, rsp_rdata=0.
- Read 0x0010 with the slave returning rdata=0xDEADBEEF and rresp=2'b00 after 3 wait cycles -> rsp_rdata=0xDEADBEEF; rready high only in RDATA.
- Write with awready 2 cycles before wready -> awvalid drops after its own handshake while wvalid stays high until its handshake; exactly one AW and one W transfer; bready only after both.
- rsp_ready held low for 5 cycles -> rsp_valid and all rsp fields stable; cmd_ready=0 throughout; the next command is accepted only after the release.
- aresetn pulsed low during WRESP -> outputs zero immediately, no rsp_valid, cmd_ready=1 after release; a following read completes normally.
- With AXI4_MASTER_TIMEOUT_EN, TIMEOUT_W=4 and a slave that never asserts arready -> after 15 RADDR cycles, arvalid=0, rsp_valid=1, rsp_resp=2'b11.
